rr_arbiter4: RTL



---
 rtl/rr_arbiter4_pkg.sv | 11 +
 rtl/rr_arbiter4_dec.sv | 16 +
 rtl/rr_arbiter4.sv | 104 ++++++++++
 3 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared types and defaults for the four-client round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter4_dec.sv
// 2-to-4 one-hot decoder with enable; output is all zeros when disabled.
module rr_arbiter4_dec (
  input  logic [1:0] in,
  input  logic       enable,
  output logic [3:0] out
);

  // Drive the single bit selected by in when enabled.
  always_comb begin
    out = '0;
    if (enable) begin
      out[in] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a hold-time limit.
// The winner index is registered and decoded to a one-hot grant.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [1:0]         win;
  logic [1:0]         cand;
  logic               hit_max;
  logic               withdrawn;

  assign hit_max   = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign withdrawn = ~req[idx_q];

  // Round-robin scan starting at ptr_q, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state logic: grant from IDLE, release from BUSY on done/withdraw/timeout.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          state_d = BUSY;
          idx_d   = win;
        end
      end
      BUSY: begin
        if (done || withdrawn || hit_max) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 2'd1;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = hit_max && !done && !withdrawn;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == BUSY);
  assign timeout     = timeout_q;

  rr_arbiter4_dec u_dec (
    .in     (idx_q),
    .enable (grant_valid),
    .out    (grant)
  );

endmodule
